// File: rtl/imm_extend_arbiter_if.sv
// Request/result bundle for imm_extend_arbiter.
//   req0/imm0/ack0 : requester 0 (decode ALU immediate)
//   req1/imm1/ack1 : requester 1 (branch offset)
//   out_valid/out_ready/out_data/out_src : result handshake to execute
//   busy           : arbiter holds a result
//   zext0/zext1    : per-request zero-extend select (only with IMM_ZERO_EXT_EN)
// master: requesters + consumer side; slave: the arbiter.
interface imm_extend_arbiter_if #(
    parameter int unsigned IN_W  = 22,
    parameter int unsigned OUT_W = 32
);
    logic             req0;
    logic [IN_W-1:0]  imm0;
    logic             ack0;
    logic             req1;
    logic [IN_W-1:0]  imm1;
    logic             ack1;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_src;
    logic             busy;
`ifdef IMM_ZERO_EXT_EN
    logic             zext0;
    logic             zext1;

    modport master (
        output req0, imm0, zext0, req1, imm1, zext1, out_ready,
        input  ack0, ack1, out_valid, out_data, out_src, busy
    );

    modport slave (
        input  req0, imm0, zext0, req1, imm1, zext1, out_ready,
        output ack0, ack1, out_valid, out_data, out_src, busy
    );
`else
    modport master (
        output req0, imm0, req1, imm1, out_ready,
        input  ack0, ack1, out_valid, out_data, out_src, busy
    );

    modport slave (
        input  req0, imm0, req1, imm1, out_ready,
        output ack0, ack1, out_valid, out_data, out_src, busy
    );
`endif
endinterface

// File: rtl/imm_extend_arbiter.sv
// Shared immediate extender: round-robin arbitration between two requesters,
// sign-extends the granted IN_W-bit immediate to OUT_W bits into an output
// register with a valid/ready handshake toward execute.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : imm_extend_arbiter_if.slave (requests, acks, result handshake, busy)
// Optional feature macro: IMM_ZERO_EXT_EN adds zext0/zext1 so a request can
// select zero-extension instead of sign-extension.
module imm_extend_arbiter #(
    parameter int unsigned IN_W  = 22,
    parameter int unsigned OUT_W = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    imm_extend_arbiter_if.slave bus
);

    localparam int unsigned EXT_W = OUT_W - IN_W;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             valid_q, valid_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             src_q, src_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             busy_q, busy_d;

    logic             elig0;
    logic             elig1;
    logic             can_cap;
    logic             grant;
    logic             sel;
    logic [IN_W-1:0]  sel_imm;
    logic             fill;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
        end
    end

    // Arbitration, extension and next-state logic
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;

        // A requester whose ack is currently high has already been served;
        // its req is still visible this cycle and must not be granted again.
        elig0   = bus.req0 & ~ack0_q;
        elig1   = bus.req1 & ~ack1_q;
        can_cap = (state_q == IDLE) | bus.out_ready;
        grant   = can_cap & (elig0 | elig1);
        sel     = (elig0 & elig1) ? rr_q : elig1;
        sel_imm = sel ? bus.imm1 : bus.imm0;
`ifdef IMM_ZERO_EXT_EN
        fill    = sel_imm[IN_W-1] & ~(sel ? bus.zext1 : bus.zext0);
`else
        fill    = sel_imm[IN_W-1];
`endif

        if (grant) begin
            data_d  = {{EXT_W{fill}}, sel_imm};
            src_d   = sel;
            valid_d = 1'b1;
            ack0_d  = ~sel;
            ack1_d  = sel;
            rr_d    = ~sel;
            state_d = HOLD;
        end else if ((state_q == HOLD) && bus.out_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
        end

        busy_d = (state_d == HOLD);
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/imm_extend_arbiter.md
# imm_extend_arbiter

Shares one 22-to-32-bit immediate sign-extension datapath between two requesters: requester 0 is the decode stage's ALU immediate, requester 1 is the branch unit's offset. A round-robin arbiter grants one request at a time and captures the extended value into an output register. The register drives a valid/ready handshake to the execute stage. The block sits between decode/branch and execute and replaces the per-requester extenders.

## Interface
- IN_W, 22, immediate field width; bit IN_W-1 is the sign bit
- OUT_W, 32, extended result width; must satisfy OUT_W > IN_W
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0  input  1  requester 0 request; held high with imm0 stable until ack0
- imm0  input  IN_W  requester 0 immediate
- ack0  output  1  one-cycle pulse: requester 0 value captured
- req1  input  1  requester 1 request; same rules as req0
- imm1  input  IN_W  requester 1 immediate
- ack1  output  1  one-cycle pulse: requester 1 value captured
- out_valid  output  1  out_data/out_src hold a result
- out_ready  input  1  consumer accepts the result when high together with out_valid
- out_data  output  OUT_W  extended immediate
- out_src  output  1  requester that produced out_data (0 or 1)
- busy  output  1  high when state is HOLD

## Operation
- **Extension:** out bits [IN_W-1:0] = imm. Bits [OUT_W-1:IN_W] are copies of imm[IN_W-1]. Example: 0x200000 -> 0xFFE00000; 0x1FFFFF -> 0x001FFFFF.
- **States:** IDLE (out_valid=0) and HOLD (out_valid=1).
- **Eligible requester:** reqN high and ackN currently low. The requester drops req in the cycle after ack, so a held req is never granted twice.
- **Capture allowed when:** state is IDLE, or state is HOLD and out_ready=1 (drain and refill in the same cycle).
- **Grant:**
  - Only one requester eligible: grant it.
  - Both eligible: grant the one selected by rr_ptr. rr_ptr=0 favours requester 0.
  - After every grant, rr_ptr points to the requester that was not granted.
- **On capture:**
  - Load out_data and out_src.
  - Set out_valid.
  - Pulse ackN for exactly one cycle.
  - Go to, or stay in, HOLD.
- **HOLD, out_ready=1, no eligible request:** clear out_valid and go to IDLE.
- **HOLD, out_ready=0:** out_data, out_src and out_valid hold stable; no capture occurs and pending requests wait.
- Data from an un-granted requester is never sampled.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, ack0=0, ack1=0, busy=0, rr_ptr=0, state=IDLE.
- Latency: request eligible before edge N -> out_valid, ackN and out_data valid in cycle N+1 (1 cycle).
- Throughput: one result per cycle while out_ready stays high and requests alternate or are continuous.
- Requests from both requesters at the same edge: one grant only. The loser waits at least one cycle.
- Worst-case wait with out_ready held high: 2 cycles.
- Reset asserted mid-transfer: outputs clear immediately (asynchronously) and the held result is discarded. Requesters re-request after rst_n deasserts.
- rst_n deassertion is synchronised externally; the first capture can occur at the first edge after release.

## Configuration
- **IMM_ZERO_EXT_EN defined:**
  - Adds input ports zext0 and zext1 (1 bit each), sampled with immN at grant.
  - zextN=1 fills the upper OUT_W-IN_W bits with 0 instead of the sign bit.
  - Used for logical-immediate instructions.
- **IMM_ZERO_EXT_EN undefined:** these ports do not exist and every capture sign-extends.

## Test plan
- Reset, then req0 with imm0=0x200000 and out_ready=1:
  - ack0 and out_valid high in the next cycle.
  - out_data=0xFFE00000, out_src=0.
  - Block returns to IDLE one cycle later.
- req0 and req1 at the same edge (imm0=0x000005, imm1=0x3FFFFF), out_ready=1:
  - Cycle 1: out_data=0x00000005, src 0.
  - Cycle 2: out_data=0xFFFFFFFF, src 1.
  - rr_ptr=0 afterwards.
- Backpressure: out_ready=0 for 4 cycles with result 0x001FFFFF held while req1 is pending:
  - out_data stays stable and ack1 stays low.
  - On the cycle out_ready rises, the new value is captured and ack1 pulses.
- Continuous req0 and req1 for 8 cycles, out_ready=1:
  - Grants strictly alternate 0,1,0,1...
  - No ack is longer than 1 cycle.
  - out_valid stays high throughout.
- rst_n pulsed low while in HOLD with out_valid=1:
  - out_valid, ack0 and ack1 drop to 0 without waiting for a clock edge.
  - The first grant after release goes to requester 0.
- With IMM_ZERO_EXT_EN defined: imm1=0x200000 and zext1=1 -> out_data=0x00200000. With zext1=0 -> 0xFFE00000.
